// File: rtl/retire_trace_pkg.sv
// rtl/retire_trace_pkg.sv - shared record type and defaults for the retire trace serializer
package retire_trace_pkg;

   localparam int DEPTH_DEFAULT = 8;

   typedef struct packed {
      logic        port;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        wren;
      logic [4:0]  wrdst;
      logic [31:0] wrdata;
      logic [31:0] timer;
      logic [31:0] seq;
   } trace_rec_t;

   // Saturating add of a 0..2 record drop increment onto the 16-bit drop counter
   function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, acc} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/retire_trace_fifo.sv
// rtl/retire_trace_fifo.sv - two-write, one-read record FIFO with registered occupancy
module retire_trace_fifo
   import retire_trace_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr0_en_i,
   input  trace_rec_t    wr0_rec_i,
   input  logic          wr1_en_i,
   input  trace_rec_t    wr1_rec_i,
   input  logic          rd_en_i,
   output trace_rec_t    rd_rec_o,
   output logic [CW-1:0] count_o
);

   trace_rec_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Next pointers and occupancy; pointer arithmetic wraps naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr0_en_i) + AW'(wr1_en_i);
      rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
      count_d  = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
   end

   // Record storage; the second write lands in the slot after the first
   always_ff @(posedge clk_i) begin
      if (wr0_en_i) mem_q[wr_ptr_q] <= wr0_rec_i;
      if (wr1_en_i) mem_q[wr_ptr_q + AW'(1)] <= wr1_rec_i;
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_rec_o = mem_q[rd_ptr_q];
   assign count_o  = count_q;

endmodule

// File: rtl/retire_trace_serializer.sv
// rtl/retire_trace_serializer.sv - merges two retire ports into one sequenced trace stream
module retire_trace_serializer
   import retire_trace_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in0_valid,
   input  logic [31:0] in0_pc,
   input  logic [31:0] in0_inst,
   input  logic        in0_wren,
   input  logic [4:0]  in0_wrdst,
   input  logic [31:0] in0_wrdata,
   input  logic [31:0] in0_timer,
   input  logic        in1_valid,
   input  logic [31:0] in1_pc,
   input  logic [31:0] in1_inst,
   input  logic        in1_wren,
   input  logic [4:0]  in1_wrdst,
   input  logic [31:0] in1_wrdata,
   input  logic [31:0] in1_timer,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_port,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_wren,
   output logic [4:0]  out_wrdst,
   output logic [31:0] out_wrdata,
   output logic [31:0] out_timer,
   output logic [31:0] out_seq,
   output logic [15:0] drop_count,
   output logic        overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]    n_in, n_enq;
   logic [CW-1:0] count, free_slots;
   logic          fits, enq_first, enq_second, drop_cycle, rd_en;
   trace_rec_t    rec0, rec1, first_rec, head;
   logic [31:0]   seq_q, seq_d;
   logic [15:0]   drop_q, drop_d;
   logic          ovf_q, ovf_d;

   // Admission: all-or-nothing against free space from the registered count
   always_comb begin
      n_in       = {1'b0, in0_valid} + {1'b0, in1_valid};
      free_slots = CW'(DEPTH) - count;
      fits       = free_slots >= CW'(n_in);
      enq_first  = !reset && fits && (n_in != 2'd0);
      enq_second = !reset && fits && (n_in == 2'd2);
      drop_cycle = !reset && !fits;
      n_enq      = {1'b0, enq_first} + {1'b0, enq_second};
   end

   // Build records; port 0 takes the lower sequence number when both retire
   always_comb begin
      rec0 = '{port: 1'b0, pc: in0_pc, inst: in0_inst, wren: in0_wren, wrdst: in0_wrdst,
               wrdata: in0_wrdata, timer: in0_timer, seq: seq_q};
      rec1 = '{port: 1'b1, pc: in1_pc, inst: in1_inst, wren: in1_wren, wrdst: in1_wrdst,
               wrdata: in1_wrdata, timer: in1_timer,
               seq: (in0_valid ? seq_q + 32'd1 : seq_q)};
      first_rec = in0_valid ? rec0 : rec1;
   end

   // Next-state for sequence counter and drop bookkeeping
   always_comb begin
      seq_d  = seq_q + 32'(n_enq);
      drop_d = drop_cycle ? sat_add16(drop_q, n_in) : drop_q;
      ovf_d  = ovf_q | drop_cycle;
   end

   // Sequence, drop counter and sticky overflow registers
   always_ff @(posedge clock) begin
      if (reset) begin
         seq_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         seq_q  <= seq_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out_valid = (count != '0);
   assign rd_en     = out_valid && out_ready;

   retire_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i     (clock),
      .rst_i     (reset),
      .wr0_en_i  (enq_first),
      .wr0_rec_i (first_rec),
      .wr1_en_i  (enq_second),
      .wr1_rec_i (rec1),
      .rd_en_i   (rd_en),
      .rd_rec_o  (head),
      .count_o   (count)
   );

   assign out_port   = head.port;
   assign out_pc     = head.pc;
   assign out_inst   = head.inst;
   assign out_wren   = head.wren;
   assign out_wrdst  = head.wrdst;
   assign out_wrdata = head.wrdata;
   assign out_timer  = head.timer;
   assign out_seq    = head.seq;
   assign drop_count = drop_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_retire_trace_serializer.sv
// tb/tb_retire_trace_serializer.sv - directed self-checking bench for retire_trace_serializer
module tb_retire_trace_serializer;

   logic        clock = 1'b0;
   logic        reset;
   logic        in0_valid, in1_valid;
   logic [31:0] in0_pc, in0_inst, in0_wrdata, in0_timer;
   logic [31:0] in1_pc, in1_inst, in1_wrdata, in1_timer;
   logic        in0_wren, in1_wren;
   logic [4:0]  in0_wrdst, in1_wrdst;
   logic        out_valid, out_ready, out_port, out_wren, overflow;
   logic [31:0] out_pc, out_inst, out_wrdata, out_timer, out_seq;
   logic [4:0]  out_wrdst;
   logic [15:0] drop_count;

   int total = 0;
   int bad   = 0;

   retire_trace_serializer #(.DEPTH(8)) dut (
      .clock(clock), .reset(reset),
      .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_inst(in0_inst), .in0_wren(in0_wren),
      .in0_wrdst(in0_wrdst), .in0_wrdata(in0_wrdata), .in0_timer(in0_timer),
      .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_inst(in1_inst), .in1_wren(in1_wren),
      .in1_wrdst(in1_wrdst), .in1_wrdata(in1_wrdata), .in1_timer(in1_timer),
      .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port), .out_pc(out_pc),
      .out_inst(out_inst), .out_wren(out_wren), .out_wrdst(out_wrdst),
      .out_wrdata(out_wrdata), .out_timer(out_timer), .out_seq(out_seq),
      .drop_count(drop_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v0;
      logic        v1;
      logic [31:0] p0;
      logic [31:0] p1;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic        eport;
      logic [31:0] eseq;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_5A5A;
   endfunction
   function automatic logic [31:0] data_of(input logic [31:0] pc);
      return pc + 32'h0000_0010;
   endfunction
   function automatic logic [31:0] timer_of(input logic [31:0] pc);
      return pc ^ 32'hFFFF_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_head(input string name, input logic [31:0] pc,
                             input logic port, input logic [31:0] seq);
      check({name, ".valid"}, 32'(out_valid), 32'd1);
      if (out_valid === 1'b1) begin
         check({name, ".pc"},     out_pc,            pc);
         check({name, ".port"},   32'(out_port),     32'(port));
         check({name, ".seq"},    out_seq,           seq);
         check({name, ".inst"},   out_inst,          inst_of(pc));
         check({name, ".wrdata"}, out_wrdata,        data_of(pc));
         check({name, ".timer"},  out_timer,         timer_of(pc));
         check({name, ".wrdst"},  32'(out_wrdst),    32'(pc[6:2]));
         check({name, ".wren"},   32'(out_wren),     32'(pc[2]));
      end
   endtask

   // Drive one cycle of inputs at the falling edge; checks after this see prior edges only
   task automatic tick(input logic v0, input logic v1, input logic [31:0] p0,
                       input logic [31:0] p1, input logic rdy);
      @(negedge clock);
      in0_valid = v0; in0_pc = p0; in0_inst = inst_of(p0); in0_wrdata = data_of(p0);
      in0_timer = timer_of(p0); in0_wrdst = p0[6:2]; in0_wren = p0[2];
      in1_valid = v1; in1_pc = p1; in1_inst = inst_of(p1); in1_wrdata = data_of(p1);
      in1_timer = timer_of(p1); in1_wrdst = p1[6:2]; in1_wren = p1[2];
      out_ready = rdy;
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b1, 32'hEEEE_0000, 32'hEEEE_0004, 1'b0);
      reset = 1'b1;
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[1]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'd0};
      vecs[3]  = '{1'b1, 1'b1, 32'h100,       32'h104, 1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 32'h100,       1'b0, 32'd1};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 32'h104,       1'b1, 32'd2};
      vecs[6]  = '{1'b0, 1'b1, 32'h0,         32'h200, 1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 32'h200,       1'b1, 32'd3};
      vecs[8]  = '{1'b1, 1'b0, 32'h300,       32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[9]  = '{1'b1, 1'b0, 32'h304,       32'h0,   1'b1, 1'b1, 32'h300,       1'b0, 32'd4};
      vecs[10] = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 32'h304,       1'b0, 32'd5};
      vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[12] = '{1'b1, 1'b0, 32'h400,       32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[13] = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b1, 32'h400,       1'b0, 32'd6};
      vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b1, 32'h400,       1'b0, 32'd6};
      vecs[15] = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 32'h400,       1'b0, 32'd6};
      vecs[16] = '{1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'd0};

      reset = 1'b1;
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b0;

      // Table: single, dual, port-1-only, enqueue with dequeue, held head under backpressure
      for (int i = 0; i < 17; i++) begin
         tick(vecs[i].v0, vecs[i].v1, vecs[i].p0, vecs[i].p1, vecs[i].rdy);
         if (vecs[i].ev) check_head($sformatf("vec%0d", i), vecs[i].epc, vecs[i].eport, vecs[i].eseq);
         else check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd0);
         check($sformatf("vec%0d.drop", i), 32'(drop_count), 32'd0);
         check($sformatf("vec%0d.ovf", i), 32'(overflow), 32'd0);
      end

      // Backpressure fill to 8, fifth dual cycle dropped whole
      do_reset();
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 1'b0);
      tick(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0);
      check_head("bp.full_head", 32'h1000, 1'b0, 32'd0);
      check("bp.drop_before", 32'(drop_count), 32'd0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("bp.drop", 32'(drop_count), 32'd2);
      check("bp.ovf", 32'(overflow), 32'd1);
      for (int j = 0; j < 8; j++) begin
         tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         check_head($sformatf("bp.drain%0d", j), 32'h1000 + 32'(4*j), 1'(j & 1), 32'(j));
      end
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("bp.empty", 32'(out_valid), 32'd0);

      // Partial space: count 7 rejects dual, accepts single, then full rejects single
      do_reset();
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 32'h2000 + 32'(8*k), 32'h2004 + 32'(8*k), 1'b0);
      tick(1'b1, 1'b0, 32'h2018, 32'h0, 1'b0);
      tick(1'b1, 1'b1, 32'hBAD0_0000, 32'hBAD0_0004, 1'b0);
      check("ps.drop0", 32'(drop_count), 32'd0);
      tick(1'b0, 1'b1, 32'h0, 32'h201C, 1'b0);
      check("ps.drop2", 32'(drop_count), 32'd2);
      check("ps.ovf", 32'(overflow), 32'd1);
      tick(1'b1, 1'b0, 32'hBAD0_0008, 32'h0, 1'b0);
      check("ps.drop2b", 32'(drop_count), 32'd2);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("ps.drop3", 32'(drop_count), 32'd3);
      for (int j = 0; j < 8; j++) begin
         tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         check_head($sformatf("ps.drain%0d", j), 32'h2000 + 32'(4*j), 1'(j & 1), 32'(j));
      end
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("ps.empty", 32'(out_valid), 32'd0);

      // Reset mid-stream with five records queued and inputs active during reset
      tick(1'b1, 1'b1, 32'h3000, 32'h3004, 1'b0);
      tick(1'b1, 1'b1, 32'h3008, 32'h300C, 1'b0);
      tick(1'b1, 1'b0, 32'h3010, 32'h0, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check_head("rs.pre", 32'h3000, 1'b0, 32'd8);
      do_reset();
      check("rs.valid", 32'(out_valid), 32'd0);
      check("rs.drop", 32'(drop_count), 32'd0);
      check("rs.ovf", 32'(overflow), 32'd0);
      tick(1'b1, 1'b0, 32'h4000, 32'h0, 1'b1);
      check("rs.valid2", 32'(out_valid), 32'd0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check_head("rs.first", 32'h4000, 1'b0, 32'd0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("rs.empty", 32'(out_valid), 32'd0);

      // Drop counter saturation at 0xFFFF
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 32'h5000 + 32'(8*k), 32'h5004 + 32'(8*k), 1'b0);
      for (int k = 0; k < 32767; k++) tick(1'b1, 1'b1, 32'h6000, 32'h6004, 1'b0);
      tick(1'b1, 1'b1, 32'h6000, 32'h6004, 1'b0);
      check("sat.fffe", 32'(drop_count), 32'h0000_FFFE);
      tick(1'b1, 1'b0, 32'h6000, 32'h0, 1'b0);
      check("sat.ffff", 32'(drop_count), 32'h0000_FFFF);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("sat.hold", 32'(drop_count), 32'h0000_FFFF);
      check("sat.ovf", 32'(overflow), 32'd1);
      check_head("sat.head", 32'h5000, 1'b0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
